// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU.
// Holds the opcodes, the sequencer state encoding and the instruction field widths.
package cpu_pkg;

  localparam int CPU_IW  = 16;
  localparam int CPU_OPW = 4;
  localparam int CPU_AW  = CPU_IW - CPU_OPW;

  localparam logic [CPU_OPW-1:0] OP_NOP   = 4'h0;
  localparam logic [CPU_OPW-1:0] OP_LOAD  = 4'h1;
  localparam logic [CPU_OPW-1:0] OP_STORE = 4'h2;
  localparam logic [CPU_OPW-1:0] OP_ADD   = 4'h3;
  localparam logic [CPU_OPW-1:0] OP_SUB   = 4'h4;
  localparam logic [CPU_OPW-1:0] OP_AND   = 4'h5;
  localparam logic [CPU_OPW-1:0] OP_OR    = 4'h6;
  localparam logic [CPU_OPW-1:0] OP_NOT   = 4'h7;
  localparam logic [CPU_OPW-1:0] OP_JMP   = 4'h8;
  localparam logic [CPU_OPW-1:0] OP_JZ    = 4'h9;
  localparam logic [CPU_OPW-1:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/instr_class.sv
// Combinational opcode classifier used by the control sequencer.
// Undefined opcodes (A-E) raise only is_illegal and therefore behave as NOP.
module instr_class
  import cpu_pkg::*;
(
  input  logic [CPU_OPW-1:0] opcode,
  output logic               is_alu_wr,
  output logic               is_store,
  output logic               is_jmp,
  output logic               is_jz,
  output logic               is_halt,
  output logic               is_illegal
);

  // Map each opcode onto its instruction class
  always_comb begin
    is_alu_wr  = 1'b0;
    is_store   = 1'b0;
    is_jmp     = 1'b0;
    is_jz      = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: is_alu_wr = 1'b1;
      OP_STORE: is_store = 1'b1;
      OP_JMP:   is_jmp   = 1'b1;
      OP_JZ:    is_jz    = 1'b1;
      OP_HALT:  is_halt  = 1'b1;
      OP_NOP:   is_alu_wr = 1'b0;
      default:  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control sequencer: owns the IR and steps each instruction through
// FETCH/DECODE/EXEC/WB, issuing one-cycle Moore strobes to the PC, accumulator and memory.
module multicycle_cu
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int IW    = CPU_IW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic [IW-1:0]    ins_in,
  input  logic             zero_flag,
  output logic [IW-1:0]    ir,
  output logic [3:0]       op,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_load,
  output logic             acc_we,
  output logic             mem_we,
  output logic             halted,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IW-1:0]    ir_r;
  logic [CNT_W-1:0] cnt_r;
  logic             illegal_r;
  logic [3:0]       opcode_s;
  logic             is_alu_wr_s;
  logic             is_store_s;
  logic             is_jmp_s;
  logic             is_jz_s;
  logic             is_halt_s;
  logic             is_illegal_s;

  assign opcode_s = ir_r[IW-1 -: 4];

  instr_class u_class (
    .opcode     (opcode_s),
    .is_alu_wr  (is_alu_wr_s),
    .is_store   (is_store_s),
    .is_jmp     (is_jmp_s),
    .is_jz      (is_jz_s),
    .is_halt    (is_halt_s),
    .is_illegal (is_illegal_s)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Instruction register, saturating retire counter and sticky illegal flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_r      <= '0;
      cnt_r     <= '0;
      illegal_r <= 1'b0;
    end else begin
      if (state_r == ST_FETCH) begin
        ir_r <= ins_in;
      end
      if ((state_r == ST_DECODE) && is_illegal_s) begin
        illegal_r <= 1'b1;
      end
      if ((state_r == ST_WB) && (cnt_r != '1)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // Next-state logic; step_mode only matters in IDLE and at the end of WB
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((start && !step_mode) || (step && step_mode)) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH:  state_nxt_s = ST_DECODE;
      ST_DECODE: begin
        if (is_halt_s) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt_s = ST_WB;
      ST_WB: begin
        if (step_mode) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Strobe and op decode from registered state and IR; only JZ looks at a live input
  always_comb begin
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_load = 1'b0;
    acc_we  = 1'b0;
    mem_we  = 1'b0;
    op      = 4'h0;
    case (state_r)
      ST_FETCH: ir_we = 1'b1;
      ST_DECODE, ST_EXEC: op = opcode_s;
      ST_WB: begin
        op     = opcode_s;
        pc_we  = 1'b1;
        acc_we = is_alu_wr_s;
        mem_we = is_store_s;
        if (is_jmp_s) begin
          pc_load = 1'b1;
        end else if (is_jz_s) begin
          pc_load = zero_flag;
        end else begin
          pc_load = 1'b0;
        end
      end
      default: op = 4'h0;
    endcase
  end

  assign ir          = ir_r;
  assign state       = state_r;
  assign halted      = (state_r == ST_HALT);
  assign illegal     = illegal_r;
  assign instr_count = cnt_r;

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed self-checking bench for multicycle_cu; a small PC model feeds ins_in from a program table.
// A second, narrow-counter instance exercises retire-counter saturation.
`timescale 1ns/1ps
module tb_multicycle_cu;

  logic        clk = 1'b0;
  logic        rst, start, step_mode, step, zero_flag;
  logic [15:0] ins_in;
  logic [15:0] ir;
  logic [3:0]  op;
  logic        ir_we, pc_we, pc_load, acc_we, mem_we, halted, illegal;
  logic [2:0]  state;
  logic [15:0] instr_count;

  logic        start_sat;
  logic [15:0] ins_sat;
  logic [15:0] sat_ir;
  logic [3:0]  sat_op;
  logic        sat_ir_we, sat_pc_we, sat_pc_load, sat_acc_we, sat_mem_we, sat_halted, sat_illegal;
  logic [2:0]  sat_state;
  logic [2:0]  sat_count;

  logic [15:0] prog [16];
  logic [11:0] pc;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  multicycle_cu #(.CNT_W(16), .IW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
    .ins_in(ins_in), .zero_flag(zero_flag), .ir(ir), .op(op), .ir_we(ir_we),
    .pc_we(pc_we), .pc_load(pc_load), .acc_we(acc_we), .mem_we(mem_we),
    .halted(halted), .illegal(illegal), .state(state), .instr_count(instr_count)
  );

  multicycle_cu #(.CNT_W(3), .IW(16)) u_sat (
    .clk(clk), .rst(rst), .start(start_sat), .step_mode(step_mode), .step(step),
    .ins_in(ins_sat), .zero_flag(zero_flag), .ir(sat_ir), .op(sat_op), .ir_we(sat_ir_we),
    .pc_we(sat_pc_we), .pc_load(sat_pc_load), .acc_we(sat_acc_we), .mem_we(sat_mem_we),
    .halted(sat_halted), .illegal(sat_illegal), .state(sat_state), .instr_count(sat_count)
  );

  assign ins_in = prog[pc[3:0]];

  // Reference program counter driven by the strobes
  always @(posedge clk or negedge rst) begin
    if (!rst) pc <= 12'h000;
    else if (pc_we) pc <= pc_load ? ir[11:0] : pc + 12'h001;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; step = 1'b0; step_mode = 1'b0; zero_flag = 1'b0; start_sat = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step = 1'b0; step_mode = 1'b0; zero_flag = 1'b0;
    start_sat = 1'b0; ins_sat = 16'h0000;
    for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
    #1;

    // Free-run LOAD, ADD, STORE, HALT
    prog[0] = 16'h1010; prog[1] = 16'h3011; prog[2] = 16'h2012; prog[3] = 16'hF000;
    do_reset();
    chk("rst_state", state, 3'd0);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_count", instr_count, 16'h0000);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_strobes", {ir_we, pc_we, pc_load, acc_we, mem_we, halted}, 6'b000000);
    chk("rst_op", op, 4'h0);
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("t1_ir_we", ir_we, (c == 1 || c == 5 || c == 9 || c == 13));
      chk("t1_acc_we", acc_we, (c == 4 || c == 8));
      chk("t1_mem_we", mem_we, (c == 12));
      chk("t1_pc_we", pc_we, (c == 4 || c == 8 || c == 12));
      chk("t1_halted", halted, (c >= 15));
      if (c == 1) chk("t1_op_fetch", op, 4'h0);
      if (c == 2) begin
        chk("t1_ir_load", ir, 16'h1010);
        chk("t1_op_decode", op, 4'h1);
      end
      if (c == 14) chk("t1_op_halt_decode", op, 4'hF);
    end
    chk("t1_count", instr_count, 16'h0003);
    chk("t1_state_halt", state, 3'd5);
    chk("t1_pc_frozen", pc, 12'h003);
    step_mode = 1'b1; step = 1'b1;
    tick();
    step = 1'b0; step_mode = 1'b0;
    tick();
    chk("t1_halt_terminal", state, 3'd5);
    chk("t1_halt_count", instr_count, 16'h0003);

    // JZ 0x020, zero_flag sampled only in WB
    for (int i = 0; i < 16; i++) prog[i] = 16'h9020;
    do_reset();
    start = 1'b1;
    tick();
    tick();
    chk("t2_op_jz", op, 4'h9);
    tick(); zero_flag = 1'b1; #1;
    chk("t2_exec_no_pc_we", pc_we, 1'b0);
    tick(); zero_flag = 1'b0; #1;
    chk("t2_wb0_pc_we", pc_we, 1'b1);
    chk("t2_wb0_pc_load", pc_load, 1'b0);
    tick();
    chk("t2_pc_inc", pc, 12'h001);
    tick();
    tick();
    tick(); zero_flag = 1'b1; #1;
    chk("t2_wb1_pc_we", pc_we, 1'b1);
    chk("t2_wb1_pc_load", pc_load, 1'b1);
    tick();
    chk("t2_pc_jump", pc, 12'h020);
    chk("t2_refetch", state, 3'd1);

    // Single-step: pulses at cycles 3 and 20
    for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
    do_reset();
    step_mode = 1'b1; start = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      tick();
      step = (c == 3 || c == 20);
      chk("t3_state", state, (c >= 4 && c <= 7) ? c - 3 : (c >= 21 && c <= 24) ? c - 20 : 0);
      if (c == 12) chk("t3_count_one", instr_count, 16'h0001);
    end
    chk("t3_count_two", instr_count, 16'h0002);

    // Step ignored in free-run mode, then undefined opcode 0xB
    prog[0] = 16'hB123; prog[1] = 16'hF000;
    do_reset();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    chk("t4_step_ignored", state, 3'd0);
    start = 1'b1;
    tick();
    tick();
    chk("t4_illegal_decode", illegal, 1'b0);
    tick();
    chk("t4_illegal_exec", illegal, 1'b1);
    tick();
    chk("t4_wb_acc_mem", {acc_we, mem_we}, 2'b00);
    chk("t4_wb_pc", {pc_we, pc_load}, 2'b10);
    tick();
    chk("t4_count", instr_count, 16'h0001);
    chk("t4_illegal_sticky", illegal, 1'b1);
    tick();
    tick();
    chk("t4_halted", halted, 1'b1);
    chk("t4_illegal_hold", illegal, 1'b1);

    // Reset during EXEC of ADD
    prog[0] = 16'h3011; prog[1] = 16'h0000;
    do_reset();
    start = 1'b1;
    tick();
    tick();
    tick();
    chk("t5_exec", state, 3'd3);
    chk("t5_exec_op", op, 4'h3);
    #2; rst = 1'b0; #1;
    chk("t5_abort_state", state, 3'd0);
    chk("t5_abort_ir", ir, 16'h0000);
    chk("t5_abort_acc_we", acc_we, 1'b0);
    chk("t5_abort_op", op, 4'h0);
    start = 1'b0;
    tick();
    chk("t5_no_wb", {acc_we, pc_we}, 2'b00);
    rst = 1'b1;
    tick();
    tick();
    chk("t5_idle_wait", state, 3'd0);
    start = 1'b1;
    tick();
    chk("t5_restart", ir_we, 1'b1);

    // Retire counter saturation on the 3-bit instance
    do_reset();
    start_sat = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      tick();
      if (c == 9)  chk("t6_count_two", sat_count, 3'd2);
      if (c == 29) chk("t6_count_max", sat_count, 3'd7);
      if (c == 32) chk("t6_wb_pc_we", sat_pc_we, 1'b1);
      if (c == 33) begin
        chk("t6_sat_hold", sat_count, 3'd7);
        chk("t6_running", sat_state, 3'd1);
      end
      if (c == 36) chk("t6_sat_final", sat_count, 3'd7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
